// File: rtl/register_controller_if.sv
// Request/command bundle between a requester and register_controller.
// The slave modport is the controller side; the master modport is the requester side.
interface register_controller_if #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH = 3
);
  logic                   reqValidController;
  logic                   reqReadyController;
  logic [1:0]             reqOpController;
  logic [DATA_WIDTH-1:0]  reqDataController;
  logic [COUNT_WIDTH-1:0] reqCountController;
  logic [2:0]             comandController;
  logic [DATA_WIDTH-1:0]  dataController;
  logic                   doneController;
  logic [DATA_WIDTH-1:0]  mirrorController;

  modport slave (
    input  reqValidController, reqOpController, reqDataController, reqCountController,
    output reqReadyController, comandController, dataController, doneController,
    output mirrorController
  );

  modport master (
    output reqValidController, reqOpController, reqDataController, reqCountController,
    input  reqReadyController, comandController, dataController, doneController,
    input  mirrorController
  );
endinterface

// File: rtl/register_controller.sv
// Expands clear/load/shift-by-N requests into per-cycle commands for a 4-bit register.
// Define CONTROLLER_MIRROR_EN to build a shadow copy of the register value on mirrorController.
module register_controller #(
  parameter int unsigned DATA_WIDTH  = 4,
  parameter int unsigned COUNT_WIDTH = 3
) (
  input logic                  clockController,
  input logic                  resetController,
  register_controller_if.slave bus
);

  localparam int unsigned CMD_W = 3;
  localparam int unsigned LEN_W = ($clog2(DATA_WIDTH + 1) > COUNT_WIDTH) ?
                                  $clog2(DATA_WIDTH + 1) : COUNT_WIDTH;

  localparam logic [CMD_W-1:0] CMD_HOLD = 3'b000;
  localparam logic [CMD_W-1:0] CMD_RST  = 3'b001;
  localparam logic [CMD_W-1:0] CMD_LOAD = 3'b010;
  localparam logic [CMD_W-1:0] CMD_SL   = 3'b011;
  localparam logic [CMD_W-1:0] CMD_SR   = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SHIFT, S_DONE} state_e;

  state_e                state_q;
  logic [CMD_W-1:0]      cmd_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  ready_q;
  logic [LEN_W-1:0]      cnt_q;
  logic [LEN_W-1:0]      req_len_c;
  logic [LEN_W-1:0]      shift_len_c;

  // Shifting beyond the register width has no further effect, so clamp the step count.
  always_comb begin
    req_len_c   = LEN_W'(bus.reqCountController);
    shift_len_c = (req_len_c > LEN_W'(DATA_WIDTH)) ? LEN_W'(DATA_WIDTH) : req_len_c;
  end

  always_ff @(posedge clockController) begin
    if (resetController) begin
      state_q <= S_IDLE;
      cmd_q   <= CMD_HOLD;
      data_q  <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.reqValidController && ready_q) begin
            ready_q <= 1'b0;
            case (bus.reqOpController)
              2'b00: begin
                cmd_q   <= CMD_RST;
                state_q <= S_ISSUE;
              end
              2'b01: begin
                cmd_q   <= CMD_LOAD;
                data_q  <= bus.reqDataController;
                state_q <= S_ISSUE;
              end
              default: begin
                if (shift_len_c == '0) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
                end else begin
                  cmd_q   <= bus.reqOpController[0] ? CMD_SR : CMD_SL;
                  cnt_q   <= shift_len_c;
                  state_q <= S_SHIFT;
                end
              end
            endcase
          end
        end
        S_ISSUE: begin
          cmd_q   <= CMD_HOLD;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_SHIFT: begin
          if (cnt_q == LEN_W'(1)) begin
            cmd_q   <= CMD_HOLD;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.comandController   = cmd_q;
  assign bus.dataController     = data_q;
  assign bus.doneController     = done_q;
  assign bus.reqReadyController = ready_q;

`ifdef CONTROLLER_MIRROR_EN
  logic [DATA_WIDTH-1:0] mirror_q;

  // Applies the issued command at the same edge the register samples it.
  always_ff @(posedge clockController) begin
    if (resetController) begin
      mirror_q <= '0;
    end else begin
      case (cmd_q)
        CMD_RST:  mirror_q <= '0;
        CMD_LOAD: mirror_q <= data_q;
        CMD_SL:   mirror_q <= {mirror_q[DATA_WIDTH-2:0], 1'b0};
        CMD_SR:   mirror_q <= {1'b0, mirror_q[DATA_WIDTH-1:1]};
        default:  mirror_q <= mirror_q;
      endcase
    end
  end

  assign bus.mirrorController = mirror_q;
`else
  assign bus.mirrorController = '0;
`endif

endmodule
